// File: rtl/i2c_arbiter_pkg.sv
// rtl/i2c_arbiter_pkg.sv - shared state encoding, mode constants and width helper for the I2C bus arbiter
package i2c_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } arb_state_e;

  localparam int MODE_ROUND_ROBIN = 0;
  localparam int MODE_FIXED       = 1;

  function automatic int clog2_min1(input int value);
    int width;
    width = $clog2(value);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin / fixed-priority winner select over masked requests
module rr_pick
  import i2c_arbiter_pkg::*;
#(
  parameter int REQUEST_COUNT = 4,
  parameter int INDEX_WIDTH   = clog2_min1(REQUEST_COUNT)
) (
  input  logic [REQUEST_COUNT-1:0] request,
  input  logic [REQUEST_COUNT-1:0] mask,
  input  logic [INDEX_WIDTH-1:0]   pointer,
  input  logic                     fixed_mode,
  output logic [REQUEST_COUNT-1:0] winner,
  output logic [INDEX_WIDTH-1:0]   index,
  output logic                     valid
);

  // Fixed mode is simply a search that always starts at slot 0.
  always_comb begin
    int   start;
    int   slot;
    logic found;
    winner = '0;
    index  = '0;
    found  = 1'b0;
    slot   = 0;
    start  = fixed_mode ? 0 : int'(pointer);
    for (int offset = 0; offset < REQUEST_COUNT; offset++) begin
      slot = start + offset;
      if (slot >= REQUEST_COUNT) slot = slot - REQUEST_COUNT;
      if (!found && request[slot] && !mask[slot]) begin
        found        = 1'b1;
        winner[slot] = 1'b1;
        index        = INDEX_WIDTH'(slot);
      end
    end
    valid = found;
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - shared I2C bus arbiter with guard interval, grant watchdog and drive masking
module i2c_bus_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int REQUEST_COUNT  = 4,
  parameter int PRIORITY_MODE  = MODE_ROUND_ROBIN,
  parameter int GUARD_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int INDEX_WIDTH    = clog2_min1(REQUEST_COUNT)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [REQUEST_COUNT-1:0] request,
  output logic [REQUEST_COUNT-1:0] grant,
  input  logic [REQUEST_COUNT-1:0] scl_output,
  input  logic [REQUEST_COUNT-1:0] sda_output,
  output logic                     scl_bus_output,
  output logic                     sda_bus_output,
  output logic                     busy,
  output logic                     timeout,
  output logic [INDEX_WIDTH-1:0]   timeout_index
);

  localparam int COUNT_LIMIT = (GUARD_CYCLES > TIMEOUT_CYCLES) ? GUARD_CYCLES : TIMEOUT_CYCLES;
  localparam int COUNT_WIDTH = clog2_min1(COUNT_LIMIT + 1);
  localparam logic [COUNT_WIDTH-1:0] GUARD_LOAD =
    COUNT_WIDTH'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST =
    COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(REQUEST_COUNT - 1);
  localparam logic FIXED_MODE = (PRIORITY_MODE == MODE_FIXED);

  arb_state_e                 state, state_next;
  logic [REQUEST_COUNT-1:0]   grant_next;
  logic [REQUEST_COUNT-1:0]   lockout, lockout_next;
  logic [INDEX_WIDTH-1:0]     owner, owner_next;
  logic [INDEX_WIDTH-1:0]     pointer, pointer_next;
  logic [INDEX_WIDTH-1:0]     timeout_index_next;
  logic [COUNT_WIDTH-1:0]     count, count_next;
  logic                       timeout_next;

  logic [REQUEST_COUNT-1:0]   pick_winner;
  logic [INDEX_WIDTH-1:0]     pick_index;
  logic                       pick_valid;

  rr_pick #(
    .REQUEST_COUNT(REQUEST_COUNT),
    .INDEX_WIDTH  (INDEX_WIDTH)
  ) u_pick (
    .request   (request),
    .mask      (lockout),
    .pointer   (pointer),
    .fixed_mode(FIXED_MODE),
    .winner    (pick_winner),
    .index     (pick_index),
    .valid     (pick_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      grant         <= '0;
      lockout       <= '0;
      owner         <= '0;
      pointer       <= '0;
      count         <= '0;
      timeout       <= 1'b0;
      timeout_index <= '0;
    end else begin
      state         <= state_next;
      grant         <= grant_next;
      lockout       <= lockout_next;
      owner         <= owner_next;
      pointer       <= pointer_next;
      count         <= count_next;
      timeout       <= timeout_next;
      timeout_index <= timeout_index_next;
    end
  end

  always_comb begin
    logic leave;
    state_next         = state;
    grant_next         = grant;
    owner_next         = owner;
    pointer_next       = pointer;
    count_next         = count;
    timeout_next       = 1'b0;
    timeout_index_next = timeout_index;
    // A revoked client is re-armed only by sampling its request low.
    lockout_next       = lockout & request;
    leave              = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next   = GRANT;
          grant_next   = pick_winner;
          owner_next   = pick_index;
          count_next   = '0;
          pointer_next = (pick_index == LAST_INDEX) ? '0 : pick_index + 1'b1;
        end
      end
      GRANT: begin
        if (!request[owner]) begin
          leave = 1'b1;
        end else if (TIMEOUT_CYCLES > 0 && count == TIMEOUT_LAST) begin
          leave                = 1'b1;
          timeout_next         = 1'b1;
          timeout_index_next   = owner;
          lockout_next[owner]  = 1'b1;
        end else if (count != '1) begin
          count_next = count + 1'b1;
        end
        if (leave) begin
          grant_next = '0;
          if (GUARD_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next = GUARD;
            count_next = GUARD_LOAD;
          end
        end
      end
      GUARD: begin
        if (count == '0) state_next = IDLE;
        else             count_next = count - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Non-granted clients are forced to released (1) so they cannot disturb the bus.
  assign scl_bus_output = &(scl_output | ~grant);
  assign sda_bus_output = &(sda_output | ~grant);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - directed self-checking bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;
  import i2c_arbiter_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [3:0] req_rr, scl_rr, sda_rr, grant_rr;
  logic       sclb_rr, sdab_rr, busy_rr, to_rr;
  logic [1:0] tidx_rr;

  logic [3:0] req_fx, scl_fx, sda_fx, grant_fx;
  logic       sclb_fx, sdab_fx, busy_fx, to_fx;
  logic [1:0] tidx_fx;

  logic [3:0] req_wd, scl_wd, sda_wd, grant_wd;
  logic       sclb_wd, sdab_wd, busy_wd, to_wd;
  logic [1:0] tidx_wd;

  logic [0:0] req_e, scl_e, sda_e, grant_e, tidx_e;
  logic       sclb_e, sdab_e, busy_e, to_e;

  i2c_bus_arbiter #(.REQUEST_COUNT(4), .PRIORITY_MODE(MODE_ROUND_ROBIN), .GUARD_CYCLES(4), .TIMEOUT_CYCLES(0)) u_rr (
    .clock(clock), .reset_n(reset_n), .request(req_rr), .grant(grant_rr),
    .scl_output(scl_rr), .sda_output(sda_rr), .scl_bus_output(sclb_rr), .sda_bus_output(sdab_rr),
    .busy(busy_rr), .timeout(to_rr), .timeout_index(tidx_rr));

  i2c_bus_arbiter #(.REQUEST_COUNT(4), .PRIORITY_MODE(MODE_FIXED), .GUARD_CYCLES(4), .TIMEOUT_CYCLES(0)) u_fx (
    .clock(clock), .reset_n(reset_n), .request(req_fx), .grant(grant_fx),
    .scl_output(scl_fx), .sda_output(sda_fx), .scl_bus_output(sclb_fx), .sda_bus_output(sdab_fx),
    .busy(busy_fx), .timeout(to_fx), .timeout_index(tidx_fx));

  i2c_bus_arbiter #(.REQUEST_COUNT(4), .PRIORITY_MODE(MODE_ROUND_ROBIN), .GUARD_CYCLES(4), .TIMEOUT_CYCLES(100)) u_wd (
    .clock(clock), .reset_n(reset_n), .request(req_wd), .grant(grant_wd),
    .scl_output(scl_wd), .sda_output(sda_wd), .scl_bus_output(sclb_wd), .sda_bus_output(sdab_wd),
    .busy(busy_wd), .timeout(to_wd), .timeout_index(tidx_wd));

  i2c_bus_arbiter #(.REQUEST_COUNT(1), .PRIORITY_MODE(MODE_ROUND_ROBIN), .GUARD_CYCLES(0), .TIMEOUT_CYCLES(0)) u_e (
    .clock(clock), .reset_n(reset_n), .request(req_e), .grant(grant_e),
    .scl_output(scl_e), .sda_output(sda_e), .scl_bus_output(sclb_e), .sda_bus_output(sdab_e),
    .busy(busy_e), .timeout(to_e), .timeout_index(tidx_e));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int         idx;
    int         gap;
    logic [3:0] seen;

    req_rr = '0; scl_rr = '1; sda_rr = '1;
    req_fx = '0; scl_fx = '1; sda_fx = '1;
    req_wd = '0; scl_wd = '1; sda_wd = '1;
    req_e  = '0; scl_e  = '1; sda_e  = '1;
    #2 reset_n = 1'b0;
    repeat (3) tick;

    check_eq("reset_grant", 32'(grant_rr), 0);
    check_eq("reset_busy", 32'(busy_rr), 0);
    check_eq("reset_timeout", 32'(to_wd), 0);
    check_eq("reset_tidx", 32'(tidx_wd), 0);
    check_eq("reset_scl_bus", 32'(sclb_rr), 1);
    check_eq("reset_sda_bus", 32'(sdab_rr), 1);
    reset_n = 1'b1;
    tick;

    // Round-robin fairness: all four held, each released 10 cycles after its grant.
    req_rr = 4'b1111;
    tick;
    for (int n = 0; n < 5; n++) begin
      idx = n % 4;
      if (n > 0) begin
        gap = 0;
        while (grant_rr == 4'b0000 && gap < 40) begin
          tick;
          gap++;
        end
        check_eq("rr_gap", 32'(gap), 5);
        scl_rr = '1;
        sda_rr = '1;
      end
      check_eq("rr_grant", 32'(grant_rr), 32'(1) << idx);
      if (n < 4) begin
        repeat (10) tick;
        req_rr[idx] = 1'b0;
        tick;
        check_eq("rr_release", 32'(grant_rr), 0);
        check_eq("rr_guard_busy", 32'(busy_rr), 1);
        scl_rr = '0;
        sda_rr = '0;
        #1;
        check_eq("guard_scl_bus", 32'(sclb_rr), 1);
        check_eq("guard_sda_bus", 32'(sdab_rr), 1);
        req_rr[idx] = 1'b1;
      end
    end

    // Masking with client 0 granted, client 2 idle but pulling low.
    req_rr[2] = 1'b0;
    scl_rr = 4'b1011; sda_rr = 4'b1011;
    #1;
    check_eq("mask_scl_high", 32'(sclb_rr), 1);
    check_eq("mask_sda_high", 32'(sdab_rr), 1);
    scl_rr = 4'b0000;
    #1;
    check_eq("mask_scl_low", 32'(sclb_rr), 0);
    scl_rr = 4'b0001; sda_rr = 4'b0000;
    #1;
    check_eq("mask_scl_others", 32'(sclb_rr), 1);
    check_eq("mask_sda_owner", 32'(sdab_rr), 0);

    // Asynchronous reset between clock edges while granted.
    tick;
    scl_rr = 4'b1110; sda_rr = 4'b1110;
    #1;
    check_eq("pre_reset_grant", 32'(grant_rr), 1);
    check_eq("pre_reset_scl", 32'(sclb_rr), 0);
    #1 reset_n = 1'b0;
    #1;
    check_eq("async_grant", 32'(grant_rr), 0);
    check_eq("async_scl_bus", 32'(sclb_rr), 1);
    check_eq("async_sda_bus", 32'(sdab_rr), 1);
    check_eq("async_busy", 32'(busy_rr), 0);
    req_rr = 4'b1111; scl_rr = '1; sda_rr = '1;
    #1 reset_n = 1'b1;
    tick;
    check_eq("reset_first_winner", 32'(grant_rr), 1);
    req_rr = '0;
    repeat (8) tick;

    // Fixed priority: 2 and 3 together, 1 arrives during 2's grant.
    req_fx = 4'b1100;
    tick;
    check_eq("fx_first", 32'(grant_fx), 32'h4);
    repeat (3) tick;
    req_fx[1] = 1'b1;
    repeat (3) tick;
    check_eq("fx_no_preempt", 32'(grant_fx), 32'h4);
    req_fx[2] = 1'b0;
    tick;
    check_eq("fx_release", 32'(grant_fx), 0);
    gap = 0;
    while (grant_fx == 4'b0000 && gap < 40) begin tick; gap++; end
    check_eq("fx_gap", 32'(gap), 5);
    check_eq("fx_second", 32'(grant_fx), 32'h2);
    repeat (4) tick;
    req_fx[1] = 1'b0;
    tick;
    gap = 0;
    while (grant_fx == 4'b0000 && gap < 40) begin tick; gap++; end
    check_eq("fx_third", 32'(grant_fx), 32'h8);
    req_fx = '0;
    repeat (8) tick;

    // Watchdog: client 1 holds forever.
    req_wd[1] = 1'b1;
    tick;
    check_eq("wd_grant", 32'(grant_wd), 32'h2);
    repeat (99) tick;
    check_eq("wd_hold_99", 32'(grant_wd), 32'h2);
    check_eq("wd_no_pulse_yet", 32'(to_wd), 0);
    tick;
    check_eq("wd_revoked", 32'(grant_wd), 0);
    check_eq("wd_pulse", 32'(to_wd), 1);
    check_eq("wd_index", 32'(tidx_wd), 1);
    tick;
    check_eq("wd_pulse_end", 32'(to_wd), 0);
    seen = '0;
    repeat (30) begin
      tick;
      seen = seen | grant_wd;
    end
    check_eq("wd_locked_out", 32'(seen), 0);
    check_eq("wd_idle_busy", 32'(busy_wd), 0);
    req_wd[1] = 1'b0;
    tick;
    req_wd[1] = 1'b1;
    tick;
    check_eq("wd_regrant", 32'(grant_wd), 32'h2);
    check_eq("wd_index_hold", 32'(tidx_wd), 1);
    repeat (99) tick;
    req_wd[1] = 1'b0;
    tick;
    check_eq("wd_tie_release", 32'(grant_wd), 0);
    check_eq("wd_tie_no_pulse", 32'(to_wd), 0);
    req_wd[1] = 1'b1;
    gap = 0;
    while (grant_wd == 4'b0000 && gap < 40) begin tick; gap++; end
    check_eq("wd_tie_no_lockout", 32'(grant_wd), 32'h2);
    check_eq("wd_tie_gap", 32'(gap), 5);
    req_wd = '0;
    repeat (8) tick;

    // Single requester, no guard interval.
    req_e = 1'b1;
    tick;
    check_eq("e_grant", 32'(grant_e), 1);
    scl_e = 1'b0;
    #1;
    check_eq("e_scl_bus", 32'(sclb_e), 0);
    scl_e = 1'b1;
    repeat (2) tick;
    req_e = 1'b0;
    tick;
    check_eq("e_release", 32'(grant_e), 0);
    check_eq("e_release_busy", 32'(busy_e), 0);
    req_e = 1'b1;
    tick;
    check_eq("e_regrant", 32'(grant_e), 1);
    req_e = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
